// File: rtl/line_buffer_3row.sv
// Three-row vertical tap generator for a 3x3 window: two line memories hold rows y-1 and y-2,
// raster coordinates come from a sof-anchored column/row counter, and outputs are registered once.
module line_buffer_3row #(
  parameter int DATA_W     = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  input  logic              sof,
  output logic [DATA_W-1:0] row0_out,
  output logic [DATA_W-1:0] row1_out,
  output logic [DATA_W-1:0] row2_out,
  output logic              pixel_valid_out,
  output logic [10:0]       x_out,
  output logic [9:0]        y_out,
  output logic              rows_ready,
  output logic              frame_done
);

  localparam int          AW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [10:0] X_LAST = 11'(IMG_WIDTH - 1);
  localparam logic [9:0]  Y_LAST = 10'(IMG_HEIGHT - 1);

  logic [10:0]       col_cnt;
  logic [9:0]        row_cnt;
  logic [DATA_W-1:0] lb_a [IMG_WIDTH];
  logic [DATA_W-1:0] lb_b [IMG_WIDTH];

  logic              accept;
  logic [10:0]       tag_x;
  logic [9:0]        tag_y;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic              tag_last;

  // A sof pixel is always (0,0) regardless of where the counters were.
  assign accept   = pix_valid & ~reset;
  assign tag_x    = sof ? 11'd0 : col_cnt;
  assign tag_y    = sof ? 10'd0 : row_cnt;
  assign addr     = tag_x[AW-1:0];
  assign rd_a     = lb_a[addr];
  assign rd_b     = lb_b[addr];
  assign tag_last = (tag_x == X_LAST) && (tag_y == Y_LAST);

  // Line memories are never cleared; stale content is hidden by the y masking below.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_b[addr] <= rd_a;
      lb_a[addr] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_cnt         <= '0;
      row_cnt         <= '0;
      row0_out        <= '0;
      row1_out        <= '0;
      row2_out        <= '0;
      pixel_valid_out <= 1'b0;
      x_out           <= '0;
      y_out           <= '0;
      rows_ready      <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      pixel_valid_out <= pix_valid;
      rows_ready      <= pix_valid && (tag_y >= 10'd2);
      frame_done      <= pix_valid && tag_last;
      if (pix_valid) begin
        row2_out <= pix_in;
        row1_out <= (tag_y == 10'd0) ? '0 : rd_a;
        row0_out <= (tag_y <  10'd2) ? '0 : rd_b;
        x_out    <= tag_x;
        y_out    <= tag_y;
        if (sof) begin
          col_cnt <= 11'd1;
          row_cnt <= 10'd0;
        end else if (col_cnt == X_LAST) begin
          col_cnt <= 11'd0;
          row_cnt <= (row_cnt == Y_LAST) ? 10'd0 : row_cnt + 10'd1;
        end else begin
          col_cnt <= col_cnt + 11'd1;
        end
      end
    end
  end

endmodule

// File: doc/line_buffer_3row.md
Name: line_buffer_3row

Overview:
- Producer side of the 3x3 window path. Accepts a raster pixel stream, one pixel per valid cycle.
- Stores the two previous image rows in on-chip line memories.
- Emits three vertically aligned taps: row0 = y-2, row1 = y-1, row2 = y. Each tap is paired with its column/row coordinate and a valid strobe, which directly drive the sliding-window stage.
- Generates the raster coordinates internally from a start-of-frame marker.

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_WIDTH, 640, pixels per row; line memory depth; 3..2047.
- IMG_HEIGHT, 480, rows per frame; 3..1023.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- pix_in  input  DATA_W  incoming pixel.
- pix_valid  input  1  pix_in valid this cycle; there is no backpressure.
- sof  input  1  start of frame; qualified by pix_valid; marks pix_in as pixel (0,0).
- row0_out  output  DATA_W  pixel at (x, y-2).
- row1_out  output  DATA_W  pixel at (x, y-1).
- row2_out  output  DATA_W  pixel at (x, y).
- pixel_valid_out  output  1  row taps and coordinates valid.
- x_out  output  11  column of the current taps.
- y_out  output  10  row of the current taps.
- rows_ready  output  1  pixel_valid_out & (y_out >= 2).
- frame_done  output  1  one-cycle pulse with the tap of pixel (IMG_WIDTH-1, IMG_HEIGHT-1).

Behaviour:
- Reset, synchronous: every output register is cleared to 0. col_cnt and row_cnt are cleared to 0. Line memories are not cleared; masking (below) hides stale data.
- Storage: two memories, each IMG_WIDTH x DATA_W.
  - lbA holds row y-1; lbB holds row y-2.
  - On an accepted pixel at column c, both are read at c. Then lbB[c] <= lbA[c] and lbA[c] <= pix_in, which is read-before-write at the same address.
- Latency: exactly 1 cycle.
  - Outputs are registered on the cycle after the accepting edge.
  - With no input, pixel_valid_out, rows_ready and frame_done drop to 0 the next cycle. Data and coordinate outputs hold their last values.
- Coordinate counters:
  - Accepted pixel with sof=1: the pixel is tagged (0,0). Then col_cnt <= 1 and row_cnt <= 0.
  - Accepted pixel with sof=0: the pixel is tagged (col_cnt,row_cnt).
    - If col_cnt = IMG_WIDTH-1: col_cnt <= 0 and row_cnt increments.
    - If row_cnt is also IMG_HEIGHT-1: both wrap to 0.
    - Otherwise col_cnt increments.
  - Cycles without pix_valid do not change counters or memories. Gaps of any length are allowed.
- Top-row masking, registered with the data:
  - row1_out = 0 when the tagged y = 0.
  - row0_out = 0 when the tagged y < 2.
  - row2_out is always pix_in.
- sof mid-frame: restarts counters immediately. Memory content from the aborted frame stays masked by the y rule above.
- reset together with pix_valid: reset wins. The pixel is dropped and no memory write occurs.
- frame_done: asserted with the output tap whose tagged coordinate is (IMG_WIDTH-1, IMG_HEIGHT-1). It is not asserted on a sof restart.
- Arithmetic: counter widths are 11 and 10 bits. Comparisons are against IMG_WIDTH-1 and IMG_HEIGHT-1. Parameters must fit these widths.

Test Plan:
1. Reset, then an IMG_WIDTH=8 / IMG_HEIGHT=4 frame with pix = y*16 + x and continuous valid.
   - At (x=3, y=2), 1 cycle later: row0=0x03, row1=0x13, row2=0x23, rows_ready=1.
2. Same frame, row 0 and row 1.
   - At (5,0): row0=0, row1=0, row2=0x05, rows_ready=0.
   - At (5,1): row0=0, row1=0x05, row2=0x15.
3. Valid toggled 1-0-0-1 through a frame.
   - Taps and coordinates match the continuous case.
   - pixel_valid_out is low for exactly the gap cycles.
   - Counters do not advance during gaps.
4. Last pixel (7,3) accepted.
   - frame_done=1 for one cycle with x_out=7, y_out=3.
   - The next accepted pixel without sof is tagged (0,0) with row0=row1=0.
5. sof asserted at the old (4,2), mid-frame.
   - That tap shows x_out=0, y_out=0, row0=row1=0, row2=pix_in.
   - Old-frame data never appears on row0 or row1 while y_out < 2.
6. reset asserted for 1 cycle while pix_valid=1 mid-row 2.
   - Next cycle all outputs are 0.
   - The next accepted pixel is tagged (0,0).
   - lbA at the dropped column is unchanged.
